// File: rtl/imem_stream_loader_if.sv
// Stream-in / instruction-memory-write bundle for the program loader.
// slave: the loader itself; master: the stream source and memory/CPU side.
interface imem_stream_loader_if #(
   parameter int unsigned ADDR_WIDTH = 10
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  im_we;
   logic [ADDR_WIDTH-1:0] im_addr;
   logic [31:0]           im_wdata;
   logic                  cpu_rst;
   logic                  done;
   logic                  error;
   logic [15:0]           words_loaded;

   modport slave (
      input  in_data, in_valid,
      output in_ready, im_we, im_addr, im_wdata, cpu_rst, done, error, words_loaded
   );

   modport master (
      output in_data, in_valid,
      input  in_ready, im_we, im_addr, im_wdata, cpu_rst, done, error, words_loaded
   );
endinterface

// File: rtl/imem_stream_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// as big-endian words and holds the CPU in reset until the frame verifies.
module imem_stream_loader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned MAX_WORDS  = 256
) (
   input logic                   clk,
   input logic                   rst,
   imem_stream_loader_if.slave   bus
);

   typedef enum logic [2:0] {
      StLenHi, StLenLo, StPayload, StCheck, StRun, StErr
   } state_e;

   state_e      state_q;
   logic [7:0]  len_hi_q;
   logic [15:0] len_q;
   logic [1:0]  byte_cnt_q;
   logic [15:0] word_idx_q;
   logic [7:0]  csum_q;
   logic [23:0] asm_q;

   logic        xfer;
   logic [15:0] len_rx;

   // in_ready is registered, so the handshake has no combinational path from in_valid
   assign xfer   = bus.in_valid && bus.in_ready;
   assign len_rx = {len_hi_q, bus.in_data};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StLenHi;
         len_hi_q         <= '0;
         len_q            <= '0;
         byte_cnt_q       <= '0;
         word_idx_q       <= '0;
         csum_q           <= '0;
         asm_q            <= '0;
         bus.in_ready     <= 1'b0;
         bus.im_we        <= 1'b0;
         bus.im_addr      <= '0;
         bus.im_wdata     <= '0;
         bus.cpu_rst      <= 1'b1;
         bus.done         <= 1'b0;
         bus.error        <= 1'b0;
         bus.words_loaded <= '0;
      end else begin
         bus.im_we <= 1'b0;
         case (state_q)
            StLenHi: begin
               bus.in_ready <= 1'b1;
               if (xfer) begin
                  len_hi_q <= bus.in_data;
                  state_q  <= StLenLo;
               end
            end
            StLenLo: begin
               if (xfer) begin
                  len_q <= len_rx;
                  if (len_rx == 16'd0) begin
                     state_q <= StCheck;
                  end else if (32'(len_rx) > MAX_WORDS) begin
                     state_q      <= StErr;
                     bus.in_ready <= 1'b0;
                     bus.error    <= 1'b1;
                  end else begin
                     state_q <= StPayload;
                  end
               end
            end
            StPayload: begin
               if (xfer) begin
                  asm_q      <= {asm_q[15:0], bus.in_data};
                  csum_q     <= csum_q ^ bus.in_data;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     bus.im_we        <= 1'b1;
                     bus.im_wdata     <= {asm_q, bus.in_data};
                     bus.im_addr      <= {word_idx_q[ADDR_WIDTH-3:0], 2'b00};
                     bus.words_loaded <= bus.words_loaded + 16'd1;
                     word_idx_q       <= word_idx_q + 16'd1;
                     if ((word_idx_q + 16'd1) == len_q) begin
                        state_q <= StCheck;
                     end
                  end
               end
            end
            StCheck: begin
               if (xfer) begin
                  bus.in_ready <= 1'b0;
                  if (bus.in_data == csum_q) begin
                     state_q     <= StRun;
                     bus.cpu_rst <= 1'b0;
                     bus.done    <= 1'b1;
                  end else begin
                     state_q   <= StErr;
                     bus.error <= 1'b1;
                  end
               end
            end
            StRun, StErr: begin
               bus.in_ready <= 1'b0;
            end
            default: begin
               state_q      <= StErr;
               bus.in_ready <= 1'b0;
               bus.error    <= 1'b1;
            end
         endcase
      end
   end

endmodule
